// File: rtl/dmem_responder.sv
// Data-memory responder for the dsd processor: word-addressed synchronous RAM in the low half,
// plus a small MMIO window (cycle counter, LED, down-timer, status/irq) in the high half.
module dmem_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr,
  output logic [DATA_W-1:0] rdata,
  output logic [15:0]       led,
  output logic              irq,
  output logic              bus_err
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [2:0] {
    SelRam,
    SelCycle,
    SelLed,
    SelTimer,
    SelStatus,
    SelNone
  } sel_e;

  sel_e                  sel;
  logic [ADDR_W-2:0]     mmio_off;
  logic [DEPTH_LOG2-1:0] ram_idx;

  logic [DATA_W-1:0] mem [Depth];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] timer_q, timer_d;
  logic [15:0]       led_q, led_d;
  logic              irq_q, irq_d;
  logic              bus_err_q, bus_err_d;
  logic              expire;

  assign mmio_off = addr[ADDR_W-2:0];
  assign ram_idx  = addr[DEPTH_LOG2-1:0];

  // Top address bit splits RAM from MMIO; RAM ignores bits above the index so it aliases.
  always_comb begin
    sel = SelNone;
    if (!addr[ADDR_W-1]) begin
      sel = SelRam;
    end else begin
      case (mmio_off)
        (ADDR_W-1)'(0): sel = SelCycle;
        (ADDR_W-1)'(1): sel = SelLed;
        (ADDR_W-1)'(2): sel = SelTimer;
        (ADDR_W-1)'(3): sel = SelStatus;
        default:        sel = SelNone;
      endcase
    end
  end

  // RAM contents survive reset, but a store presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (resetn && wr && (sel == SelRam)) begin
      mem[ram_idx] <= wdata;
    end
  end

  assign expire = (timer_q == DATA_W'(1));

  always_comb begin
    cycle_d   = cycle_q + DATA_W'(1);
    led_d     = led_q;
    timer_d   = timer_q;
    irq_d     = irq_q;
    rdata_d   = rdata_q;
    bus_err_d = (sel == SelNone);

    if (wr && (sel == SelLed)) begin
      led_d = wdata[15:0];
    end

    if (wr && (sel == SelTimer)) begin
      timer_d = wdata;
    end else if (timer_q != '0) begin
      timer_d = timer_q - DATA_W'(1);
    end

    // Expiry is checked after the clear so a simultaneous set wins.
    if (wr && (sel == SelStatus) && wdata[0]) begin
      irq_d = 1'b0;
    end
    if (expire) begin
      irq_d = 1'b1;
    end

    if (!wr) begin
      case (sel)
        SelRam:    rdata_d = mem[ram_idx];
        SelCycle:  rdata_d = cycle_q;
        SelLed:    rdata_d = DATA_W'(led_q);
        SelTimer:  rdata_d = timer_q;
        SelStatus: rdata_d = DATA_W'(irq_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q   <= '0;
      cycle_q   <= '0;
      timer_q   <= '0;
      led_q     <= '0;
      irq_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      cycle_q   <= cycle_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      irq_q     <= irq_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign rdata   = rdata_q;
  assign led     = led_q;
  assign irq     = irq_q;
  assign bus_err = bus_err_q;

endmodule
